data_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port data memory between the CPU load/store unit (port 0) and a secondary master such as a DMA or debug loader (port 1). Requests use a valid/ready handshake and are arbitrated round-robin, at most one access per cycle. The granted access drives the memory's write-enable, address and write-data inputs directly. A registered response returns read data or a write acknowledge, plus an error flag for misaligned or out-of-range addresses, one cycle after the grant.

---
 rtl/data_mem_arb_pkg.sv | 16 +
 rtl/data_mem_arbiter_if.sv | 31 +++
 rtl/rr_arbiter2.sv | 25 ++
 rtl/data_mem_arbiter.sv | 84 ++++++++
 tb/tb_data_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared constants and the request bundle for the data memory arbiter.
package data_mem_arb_pkg;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int ADDR_WIDTH_DEF  = 32;
  localparam int DEPTH_WORDS_DEF = 64;
  localparam int WORD_LSB        = 2;

  // The bundle uses the default widths; the top is used at those widths.
  typedef struct packed {
    logic                      we;
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] wdata;
  } req_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// One master port of the data memory arbiter: request handshake plus response.
interface data_mem_arbiter_if
  import data_mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

  // Handshake: a request moves when req_valid && req_ready on a rising edge;
  // the master holds valid and payload stable until then. rsp_valid is a
  // one-cycle pulse that cannot be back-pressured.
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter; prio names the winner of the next tie.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       prio
);

  // Grants are suppressed while reset is high so nothing transfers then.
  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      if (req == 2'b11) grant = prio ? 2'b10 : 2'b01;
      else              grant = req;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        prio <= 1'b0;
    else if (advance) prio <= grant[0];
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one asynchronous-read data memory between two masters, one access per cycle.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  data_mem_arbiter_if.slave     m0,
  data_mem_arbiter_if.slave     m1,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  prio
);

  localparam int IDX_W = ADDR_WIDTH - WORD_LSB;
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH_WORDS);

  logic [1:0]            grant;
  logic                  xfer;
  logic                  err;
  req_t                  sel;
  logic [DATA_WIDTH-1:0] rsp_data;

  rr_arbiter2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     ({m1.req_valid, m0.req_valid}),
    .advance (xfer),
    .grant   (grant),
    .prio    (prio)
  );

  assign m0.req_ready = grant[0];
  assign m1.req_ready = grant[1];
  assign xfer         = |grant;

  always_comb begin
    sel.we    = m0.req_we;
    sel.addr  = m0.req_addr;
    sel.wdata = m0.req_wdata;
    if (grant[1]) begin
      sel.we    = m1.req_we;
      sel.addr  = m1.req_addr;
      sel.wdata = m1.req_wdata;
    end
  end

  assign err = (sel.addr[WORD_LSB-1:0] != '0) ||
               (sel.addr[ADDR_WIDTH-1:WORD_LSB] >= DEPTH_IDX);

  // The bus idles at zero so nothing stale reaches the memory pins.
  assign mem_write_enable = xfer && sel.we && !err;
  assign mem_address      = xfer ? sel.addr  : '0;
  assign mem_write_data   = xfer ? sel.wdata : '0;
  assign rsp_data         = (!sel.we && !err) ? mem_read_data : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m0.rsp_valid <= 1'b0;
      m0.rsp_err   <= 1'b0;
      m0.rsp_rdata <= '0;
      m1.rsp_valid <= 1'b0;
      m1.rsp_err   <= 1'b0;
      m1.rsp_rdata <= '0;
    end else begin
      m0.rsp_valid <= grant[0];
      m1.rsp_valid <= grant[1];
      if (grant[0]) begin
        m0.rsp_err   <= err;
        m0.rsp_rdata <= rsp_data;
      end
      if (grant[1]) begin
        m1.rsp_err   <= err;
        m1.rsp_rdata <= rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: reference model, response scoreboard and scenario tasks.
module tb_data_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fill  = 1'b1;
  logic        mem_write_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        prio;
  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  logic [32:0] exp0_q[$];
  logic [32:0] exp1_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic        m_prio = 1'b0;
  logic [1:0]  exp_grant = 2'b00;
  logic        exp_mwe = 1'b0;
  logic [31:0] exp_maddr = '0;
  logic [31:0] exp_mwd = '0;
  event        bus_ev;

  data_mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m0_if ();
  data_mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m1_if ();

  data_mem_arbiter dut (
    .clock            (clock),
    .reset            (reset),
    .m0               (m0_if),
    .m1               (m1_if),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data),
    .prio             (prio)
  );

  // ---------------- clock / memory ----------------
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (fill) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | 32'(i * 3);
    end else if (mem_write_enable) begin
      mem[mem_address[7:2]] <= mem_write_data;
    end
  end

  assign mem_read_data = (mem_address[31:8] == 24'd0) ? mem[mem_address[7:2]] : 32'd0;

  // ---------------- monitors ----------------
  always @(bus_ev) begin
    n_cmp++;
    if ({m1_if.req_ready, m0_if.req_ready} !== exp_grant || mem_write_enable !== exp_mwe ||
        mem_address !== exp_maddr || mem_write_data !== exp_mwd || prio !== m_prio) begin
      n_fail++;
      $display("FAIL bus t=%0t: ready=%b we=%b addr=%h wd=%h prio=%b, expected ready=%b we=%b addr=%h wd=%h prio=%b",
               $time, {m1_if.req_ready, m0_if.req_ready}, mem_write_enable, mem_address,
               mem_write_data, prio, exp_grant, exp_mwe, exp_maddr, exp_mwd, m_prio);
    end
  end

  always @(negedge clock) begin
    logic [32:0] e;
    n_cmp += 2;
    if (exp0_q.size() > 0) begin
      e = exp0_q.pop_front();
      if (m0_if.rsp_valid !== 1'b1 || {m0_if.rsp_err, m0_if.rsp_rdata} !== e) begin
        n_fail++;
        $display("FAIL rsp0 t=%0t: valid=%b err=%b rdata=%h, expected valid=1 err=%b rdata=%h",
                 $time, m0_if.rsp_valid, m0_if.rsp_err, m0_if.rsp_rdata, e[32], e[31:0]);
      end
    end else if (m0_if.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rsp0_idle t=%0t: valid=%b, expected 0", $time, m0_if.rsp_valid);
    end
    if (exp1_q.size() > 0) begin
      e = exp1_q.pop_front();
      if (m1_if.rsp_valid !== 1'b1 || {m1_if.rsp_err, m1_if.rsp_rdata} !== e) begin
        n_fail++;
        $display("FAIL rsp1 t=%0t: valid=%b err=%b rdata=%h, expected valid=1 err=%b rdata=%h",
                 $time, m1_if.rsp_valid, m1_if.rsp_err, m1_if.rsp_rdata, e[32], e[31:0]);
      end
    end else if (m1_if.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rsp1_idle t=%0t: valid=%b, expected 0", $time, m1_if.rsp_valid);
    end
  end

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic v0, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic v1, input logic we1, input logic [31:0] a1, input logic [31:0] d1,
                      output logic [1:0] obs_g);
    logic g0, g1, w, e;
    logic [31:0] a, d, rd;
    m0_if.req_valid = v0; m0_if.req_we = we0; m0_if.req_addr = a0; m0_if.req_wdata = d0;
    m1_if.req_valid = v1; m1_if.req_we = we1; m1_if.req_addr = a1; m1_if.req_wdata = d1;
    g0 = v0 && (!v1 || !m_prio);
    g1 = v1 && !g0;
    a  = g1 ? a1 : a0;
    d  = g1 ? d1 : d0;
    w  = g1 ? we1 : we0;
    e  = (a[1:0] != 2'b00) || (a[31:2] >= 30'd64);
    exp_grant = {g1, g0};
    exp_mwe   = (g0 || g1) && w && !e;
    exp_maddr = (g0 || g1) ? a : 32'd0;
    exp_mwd   = (g0 || g1) ? d : 32'd0;
    #2;
    -> bus_ev;
    obs_g = {m1_if.req_ready, m0_if.req_ready};
    @(posedge clock);
    if (g0 || g1) begin
      rd = (!w && !e) ? ref_mem[a[7:2]] : 32'd0;
      if (w && !e) ref_mem[a[7:2]] = d;
      if (g0) exp0_q.push_back({e, rd});
      else    exp1_q.push_back({e, rd});
      m_prio = g0;
    end
    @(negedge clock);
  endtask

  task automatic idle();
    logic [1:0] g;
    step(0, 0, 0, 0, 0, 0, 0, 0, g);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    m0_if.req_valid = 1; m0_if.req_we = 1; m0_if.req_addr = 32'h8; m0_if.req_wdata = 32'h1;
    m1_if.req_valid = 1; m1_if.req_we = 1; m1_if.req_addr = 32'hC; m1_if.req_wdata = 32'h2;
    #1;
    n_cmp++;
    if ({m1_if.req_ready, m0_if.req_ready, mem_write_enable, prio} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ready: ready=%b we=%b prio=%b, expected all 0",
               {m1_if.req_ready, m0_if.req_ready}, mem_write_enable, prio);
    end
    n_cmp++;
    if ({m0_if.rsp_valid, m0_if.rsp_err, m0_if.rsp_rdata, m1_if.rsp_valid, m1_if.rsp_err, m1_if.rsp_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: v0=%b e0=%b d0=%h v1=%b e1=%b d1=%h, expected 0",
               m0_if.rsp_valid, m0_if.rsp_err, m0_if.rsp_rdata, m1_if.rsp_valid, m1_if.rsp_err, m1_if.rsp_rdata);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    m0_if.req_valid = 0; m1_if.req_valid = 0;
    fill  = 0;
    reset = 0;
  endtask

  task automatic test_write_read();
    logic [1:0] g;
    step(1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, g);
    step(1, 0, 32'h10, 32'h0, 0, 0, 0, 0, g);
    idle();
    n_cmp++;
    if (mem[4] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL write_read_mem: word4=%h, expected deadbeef", mem[4]);
    end
  endtask

  task automatic test_errors();
    logic [1:0] g;
    step(0, 0, 0, 0, 1, 1, 32'h102, 32'h5555_AAAA, g);
    step(0, 0, 0, 0, 1, 1, 32'h100, 32'h6666_BBBB, g);
    step(0, 0, 0, 0, 1, 0, 32'h101, 32'h0, g);
    step(0, 0, 0, 0, 1, 0, 32'hFC, 32'h0, g);
    idle();
    n_cmp++;
    if (mem[0] !== ref_mem[0] || mem[63] !== ref_mem[63]) begin
      n_fail++;
      $display("FAIL errors_mem: word0=%h word63=%h, expected %h %h", mem[0], mem[63], ref_mem[0], ref_mem[63]);
    end
  endtask

  task automatic test_contention();
    logic [1:0] g;
    logic [1:0] exp_seq [4];
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
    n_cmp++;
    if (prio !== 1'b0) begin
      n_fail++;
      $display("FAIL contention_start_prio: prio=%b, expected 0", prio);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 32'h04, 32'h0, 1, 0, 32'h08, 32'h0, g);
      n_cmp++;
      if (g !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL contention_grant[%0d]: grant=%b, expected %b", i, g, exp_seq[i]);
      end
    end
    idle();
  endtask

  task automatic test_write_visibility();
    logic [1:0] g;
    step(0, 0, 0, 0, 1, 1, 32'h20, 32'h1234_5678, g);
    step(1, 0, 32'h20, 32'h0, 0, 0, 0, 0, g);
    idle();
  endtask

  task automatic test_back_to_back();
    logic [1:0] g;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, 0, 32'(8 + 4 * i), 32'h0, g);
      n_cmp++;
      if (g !== 2'b10 || prio !== 1'b0) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: grant=%b prio=%b, expected 10 0", i, g, prio);
      end
    end
    idle();
  endtask

  task automatic test_reset_abort();
    logic [1:0] g;
    step(1, 0, 32'h4, 32'h0, 0, 0, 0, 0, g);
    m0_if.req_valid = 1; m0_if.req_we = 1; m0_if.req_addr = 32'h30; m0_if.req_wdata = 32'hCAFE_F00D;
    #2;
    n_cmp++;
    if (m0_if.req_ready !== 1'b1 || prio !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: ready=%b prio=%b, expected 1 1", m0_if.req_ready, prio);
    end
    reset = 1;
    #1;
    n_cmp++;
    if (m0_if.req_ready !== 1'b0 || mem_write_enable !== 1'b0 || prio !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_reset: ready=%b we=%b prio=%b, expected 0 0 0", m0_if.req_ready, mem_write_enable, prio);
    end
    @(posedge clock);
    #1;
    n_cmp++;
    if (m0_if.rsp_valid !== 1'b0 || mem[12] !== ref_mem[12]) begin
      n_fail++;
      $display("FAIL abort_post: rsp_valid=%b word12=%h, expected 0 %h", m0_if.rsp_valid, mem[12], ref_mem[12]);
    end
    @(negedge clock);
    m0_if.req_valid = 0;
    reset  = 0;
    m_prio = 0;
    idle();
  endtask

  task automatic test_random();
    logic [1:0]  g;
    logic [31:0] a0, a1;
    for (int i = 0; i < 60; i++) begin
      a0 = {24'd0, 4'($urandom_range(0, 15)), 2'b00};
      a1 = {24'd0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 7) == 0) a0 = a0 | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) a1 = a1 + 32'h100;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a0, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a1, $urandom, g);
    end
    idle();
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (mem[i] !== ref_mem[i]) begin
        n_fail++;
        $display("FAIL random_mem[%0d]: %h, expected %h", i, mem[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'hA500_0000 | 32'(i * 3);
    m0_if.req_valid = 0; m0_if.req_we = 0; m0_if.req_addr = 0; m0_if.req_wdata = 0;
    m1_if.req_valid = 0; m1_if.req_we = 0; m1_if.req_addr = 0; m1_if.req_wdata = 0;
    test_reset();
    test_write_read();
    test_errors();
    test_contention();
    test_write_visibility();
    test_back_to_back();
    test_reset_abort();
    test_random();
    n_cmp++;
    if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending responses %0d/%0d, expected 0/0", exp0_q.size(), exp1_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
